i2c_reg_seq: RTL and testbench

I2C_REG_SEQ -- requirements
Module: i2c_reg_seq

---
 rtl/i2c_reg_seq_if.sv | 29 ++
 rtl/i2c_reg_seq.sv | 189 ++++++++++++++++++
 tb/tb_i2c_reg_seq.sv | 339 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_reg_seq_if.sv
// rtl/i2c_reg_seq_if.sv - host and i2c_master signal bundle for the register sequencer
interface i2c_reg_seq_if;
  // host request side
  logic       req;
  logic       rnw;
  logic [6:0] dev;
  logic [7:0] rga;
  logic [7:0] wdat;
  logic       busy;
  logic       done;
  logic [1:0] err;
  logic [7:0] rdat;
  // i2c_master command side
  logic [4:0] cmd;
  logic       ws;
  logic [7:0] dat;
  logic [6:0] stat;
  logic [7:0] mdat;

  modport slave (
    input  req, rnw, dev, rga, wdat, stat, mdat,
    output busy, done, err, rdat, cmd, ws, dat
  );

  modport master (
    output req, rnw, dev, rga, wdat, stat, mdat,
    input  busy, done, err, rdat, cmd, ws, dat
  );
endinterface

// File: rtl/i2c_reg_seq.sv
// rtl/i2c_reg_seq.sv - sequences single-register I2C reads/writes into i2c_master commands
module i2c_reg_seq #(
  parameter int BBL_RETRIES = 3
) (
  input logic         clk,
  input logic         rst,
  i2c_reg_seq_if.slave bus
);

  localparam int RW = (BBL_RETRIES > 0) ? $clog2(BBL_RETRIES + 1) : 1;
  localparam logic [RW-1:0] RETRY_INIT = RW'(BBL_RETRIES);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ISSUE = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_NSTOP = 3'd3;
  localparam logic [2:0] S_FIN   = 3'd4;

  localparam logic [4:0] C_STRT = 5'b00001;
  localparam logic [4:0] C_STOP = 5'b00010;
  localparam logic [4:0] C_READ = 5'b00100;
  localparam logic [4:0] C_WRTE = 5'b01000;
  localparam logic [4:0] C_NACK = 5'b10000;

  logic [2:0]    state;
  logic [1:0]    step;
  logic [RW-1:0] retry;
  logic          nstop_sent;
  logic          rnw_q;
  logic [6:0]    dev_q;
  logic [7:0]    rga_q;
  logic [7:0]    wdat_q;
  logic [1:0]    err_q;
  logic [7:0]    rdat_q;

  logic [4:0]    step_cmd;
  logic [7:0]    step_dat;
  logic          step_last;
  logic          fire;
  logic          compl;
  logic          unused_stat;

  // ALO and BBY are only informational here; an arbitration loss shows up as ERR without BBL
  assign unused_stat = ^{bus.stat[6], bus.stat[2]};

  // command and data byte for the current step of the latched transaction
  always_comb begin
    step_cmd = 5'd0;
    step_dat = 8'h00;
    case (step)
      2'd0: begin
        step_cmd = C_STRT | C_WRTE;
        step_dat = {dev_q, 1'b0};
      end
      2'd1: begin
        step_cmd = C_WRTE;
        step_dat = rga_q;
      end
      2'd2: begin
        if (rnw_q) begin
          step_cmd = C_STRT | C_WRTE;
          step_dat = {dev_q, 1'b1};
        end else begin
          step_cmd = C_WRTE | C_STOP;
          step_dat = wdat_q;
        end
      end
      default: begin
        step_cmd = C_READ | C_NACK | C_STOP;
        step_dat = 8'h00;
      end
    endcase
  end

  assign step_last = rnw_q ? (step == 2'd3) : (step == 2'd2);

  // the strobe is issued in the same cycle the master reports not-busy, so it is exactly one cycle wide
  assign fire  = !bus.stat[5] && ((state == S_ISSUE) || ((state == S_NSTOP) && !nstop_sent));
  assign compl = bus.stat[0] && !bus.stat[5];

  // master-facing outputs are zero outside the strobe cycle
  always_comb begin
    bus.ws  = fire;
    bus.cmd = 5'd0;
    bus.dat = 8'h00;
    if (fire) begin
      if (state == S_ISSUE) begin
        bus.cmd = step_cmd;
        bus.dat = step_dat;
      end else begin
        bus.cmd = C_STOP;
      end
    end
  end

  assign bus.busy = (state == S_ISSUE) || (state == S_WAIT) || (state == S_NSTOP);
  assign bus.done = (state == S_FIN);
  assign bus.err  = err_q;
  assign bus.rdat = rdat_q;

  // transaction sequencer; err and rdat are only written on the way into FIN so they hold between dones
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      step       <= 2'd0;
      retry      <= '0;
      nstop_sent <= 1'b0;
      rnw_q      <= 1'b0;
      dev_q      <= 7'd0;
      rga_q      <= 8'h00;
      wdat_q     <= 8'h00;
      err_q      <= 2'b00;
      rdat_q     <= 8'h00;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.req) begin
            rnw_q  <= bus.rnw;
            dev_q  <= bus.dev;
            rga_q  <= bus.rga;
            wdat_q <= bus.wdat;
            step   <= 2'd0;
            retry  <= RETRY_INIT;
            state  <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (fire) begin
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (compl) begin
            if (bus.stat[1]) begin
              if (bus.stat[3]) begin
                if (retry != '0) begin
                  retry <= retry - RW'(1);
                  step  <= 2'd0;
                  state <= S_ISSUE;
                end else begin
                  err_q <= 2'b11;
                  state <= S_FIN;
                end
              end else begin
                // lost arbitration or protocol error: the bus is not ours, so no STOP
                err_q <= 2'b10;
                state <= S_FIN;
              end
            end else if (step_cmd[3] && !bus.stat[4]) begin
              if (step_cmd[1]) begin
                err_q <= 2'b01;
                state <= S_FIN;
              end else begin
                nstop_sent <= 1'b0;
                state      <= S_NSTOP;
              end
            end else if (step_last) begin
              if (rnw_q) begin
                rdat_q <= bus.mdat;
              end
              err_q <= 2'b00;
              state <= S_FIN;
            end else begin
              step  <= step + 2'd1;
              state <= S_ISSUE;
            end
          end
        end
        S_NSTOP: begin
          if (fire) begin
            nstop_sent <= 1'b1;
          end else if (nstop_sent && compl) begin
            // the NACK is the result regardless of how the STOP itself went
            err_q <= 2'b01;
            state <= S_FIN;
          end
        end
        S_FIN: begin
          step  <= 2'd0;
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_reg_seq.sv
// tb/tb_i2c_reg_seq.sv - scoreboard testbench for i2c_reg_seq with a reactive i2c_master model
module tb_i2c_reg_seq;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  i2c_reg_seq_if bus();

  i2c_reg_seq #(.BBL_RETRIES(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [12:0] exp_q[$];
  logic [6:0]  model_stat = 7'h00;
  logic        force_bsy  = 1'b0;
  logic [7:0]  rd_byte    = 8'h00;
  int          rsp_delay  = 0;
  int          nack_idx   = -1;
  int          alo_idx    = -1;
  int          bbl_left   = 0;
  int          ws_idx     = 0;

  assign bus.stat = force_bsy ? 7'h20 : model_stat;
  assign bus.mdat = rd_byte;

  // master model: every strobe is scored against the expected queue, then answered
  always begin
    @(negedge clk);
    if (bus.ws === 1'b1) begin
      logic [12:0] obs;
      logic [12:0] e;
      logic [6:0]  r;
      int          idx;
      obs = {bus.cmd, bus.dat};
      idx = ws_idx;
      ws_idx++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL ws_unexpected got cmd=%h dat=%h required no strobe", bus.cmd, bus.dat);
      end else begin
        e = exp_q.pop_front();
        if (obs !== e) begin
          errors++;
          $display("FAIL ws_cmd_dat #%0d got cmd=%h dat=%h required cmd=%h dat=%h",
                   idx, obs[12:8], obs[7:0], e[12:8], e[7:0]);
        end
      end
      r = 7'h11;
      if (bbl_left > 0 && bus.cmd[0]) begin
        r = 7'h0B;
        bbl_left--;
      end else if (idx == nack_idx) begin
        r = 7'h01;
      end else if (idx == alo_idx) begin
        r = 7'h07;
      end
      @(posedge clk); #1;
      for (int i = 0; i < rsp_delay; i++) begin
        model_stat = 7'h20;
        @(posedge clk); #1;
      end
      model_stat = r;
      @(posedge clk); #1;
      model_stat = 7'h00;
    end
  end

  task automatic push(input logic [4:0] c, input logic [7:0] d);
    exp_q.push_back({c, d});
  endtask

  task automatic push_write(input logic [6:0] d, input logic [7:0] a, input logic [7:0] w);
    push(5'h09, {d, 1'b0});
    push(5'h08, a);
    push(5'h0A, w);
  endtask

  task automatic push_read(input logic [6:0] d, input logic [7:0] a);
    push(5'h09, {d, 1'b0});
    push(5'h08, a);
    push(5'h09, {d, 1'b1});
    push(5'h16, 8'h00);
  endtask

  task automatic cfg(input int dly, input int nk, input int al, input int bb);
    rsp_delay = dly;
    nack_idx  = nk;
    alo_idx   = al;
    bbl_left  = bb;
  endtask

  task automatic start(input logic r, input logic [6:0] d, input logic [7:0] a, input logic [7:0] w);
    @(negedge clk);
    ws_idx   = 0;
    bus.req  = 1'b1;
    bus.rnw  = r;
    bus.dev  = d;
    bus.rga  = a;
    bus.wdat = w;
    @(posedge clk); #1;
    bus.req = 1'b0;
    checks++;
    if (bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_after_req got %b required 1", bus.busy);
    end
  endtask

  task automatic wait_done(input string name, input logic [1:0] e_err, input logic chk_rd, input logic [7:0] e_rd);
    int n;
    n = 0;
    @(negedge clk);
    while (bus.done !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (bus.done !== 1'b1) begin
      errors++;
      $display("FAIL %s_done_timeout got done=%b required 1", name, bus.done);
    end else begin
      checks++;
      if (bus.err !== e_err) begin
        errors++;
        $display("FAIL %s_err got %b required %b", name, bus.err, e_err);
      end
      checks++;
      if (bus.busy !== 1'b0) begin
        errors++;
        $display("FAIL %s_busy_in_done got %b required 0", name, bus.busy);
      end
      if (chk_rd) begin
        checks++;
        if (bus.rdat !== e_rd) begin
          errors++;
          $display("FAIL %s_rdat got %h required %h", name, bus.rdat, e_rd);
        end
      end
      @(negedge clk);
      checks++;
      if (bus.done !== 1'b0) begin
        errors++;
        $display("FAIL %s_done_width got %b required 0", name, bus.done);
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_missing_ws got %0d left required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic check_reset_outputs(input string name);
    checks++;
    if ({bus.busy, bus.done, bus.err, bus.rdat, bus.cmd, bus.ws, bus.dat} !== 26'd0) begin
      errors++;
      $display("FAIL %s got busy=%b done=%b err=%b rdat=%h cmd=%h ws=%b dat=%h required all 0",
               name, bus.busy, bus.done, bus.err, bus.rdat, bus.cmd, bus.ws, bus.dat);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("reset_state");
    rst = 1'b0;
  endtask

  task automatic test_bsy_hold();
    cfg(0, -1, -1, 0);
    force_bsy = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    push_write(7'h50, 8'h10, 8'hA5);
    start(1'b0, 7'h50, 8'h10, 8'hA5);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (bus.ws !== 1'b0) begin
        errors++;
        $display("FAIL ws_during_bsy got %b required 0", bus.ws);
      end
    end
    @(posedge clk); #1;
    force_bsy = 1'b0;
    wait_done("write_bsy", 2'b00, 1'b0, 8'h00);
  endtask

  task automatic test_write_delayed();
    cfg(3, -1, -1, 0);
    push_write(7'h2A, 8'hFF, 8'h5A);
    start(1'b0, 7'h2A, 8'hFF, 8'h5A);
    wait_done("write_delayed", 2'b00, 1'b0, 8'h00);
  endtask

  task automatic test_read();
    cfg(0, -1, -1, 0);
    rd_byte = 8'h3C;
    push_read(7'h50, 8'h02);
    start(1'b1, 7'h50, 8'h02, 8'h00);
    wait_done("read", 2'b00, 1'b1, 8'h3C);
    cfg(2, -1, -1, 0);
    rd_byte = 8'hC3;
    push_read(7'h7F, 8'h80);
    start(1'b1, 7'h7F, 8'h80, 8'h11);
    wait_done("read_delayed", 2'b00, 1'b1, 8'hC3);
  endtask

  task automatic test_nack();
    cfg(0, 1, -1, 0);
    push(5'h09, 8'hA0);
    push(5'h08, 8'h10);
    push(5'h02, 8'h00);
    start(1'b0, 7'h50, 8'h10, 8'hA5);
    wait_done("nack_step1", 2'b01, 1'b1, 8'hC3);
    cfg(0, 2, -1, 0);
    push_write(7'h12, 8'h34, 8'h56);
    start(1'b0, 7'h12, 8'h34, 8'h56);
    wait_done("nack_last", 2'b01, 1'b0, 8'h00);
  endtask

  task automatic test_alo();
    cfg(0, -1, 1, 0);
    push(5'h09, 8'hA0);
    push(5'h08, 8'h02);
    start(1'b1, 7'h50, 8'h02, 8'h00);
    wait_done("alo", 2'b10, 1'b1, 8'hC3);
  endtask

  task automatic test_bbl();
    cfg(0, -1, -1, 4);
    for (int i = 0; i < 4; i++) push(5'h09, 8'hA0);
    start(1'b0, 7'h50, 8'h10, 8'hA5);
    wait_done("bbl", 2'b11, 1'b0, 8'h00);
  endtask

  task automatic test_fin_req_ignored();
    int n;
    cfg(0, -1, -1, 0);
    push_write(7'h33, 8'h44, 8'h55);
    start(1'b0, 7'h33, 8'h44, 8'h55);
    n = 0;
    @(negedge clk);
    while (bus.done !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (bus.done !== 1'b1 || bus.err !== 2'b00) begin
      errors++;
      $display("FAIL fin_req_done got done=%b err=%b required 1 00", bus.done, bus.err);
    end
    bus.req = 1'b1;
    bus.rnw = 1'b0;
    @(posedge clk); #1;
    bus.req = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++;
      if (bus.busy !== 1'b0) begin
        errors++;
        $display("FAIL fin_req_ignored got busy=%b required 0", bus.busy);
      end
    end
  endtask

  task automatic test_reset_mid();
    int n;
    cfg(8, -1, -1, 0);
    rd_byte = 8'h99;
    push_read(7'h50, 8'h02);
    start(1'b1, 7'h50, 8'h02, 8'h00);
    n = 0;
    while (ws_idx < 2 && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (ws_idx < 2) begin
      errors++;
      $display("FAIL reset_mid_reach_step1 got %0d strobes required 2", ws_idx);
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_reset_outputs("reset_mid_outputs");
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    repeat (15) @(negedge clk);
    cfg(0, -1, -1, 0);
    push_write(7'h50, 8'h10, 8'hA5);
    start(1'b0, 7'h50, 8'h10, 8'hA5);
    wait_done("after_reset", 2'b00, 1'b1, 8'h00);
  endtask

  task automatic test_back_to_back();
    cfg(0, -1, -1, 0);
    push_write(7'h01, 8'h02, 8'h03);
    start(1'b0, 7'h01, 8'h02, 8'h03);
    wait_done("b2b_write", 2'b00, 1'b0, 8'h00);
    rd_byte = 8'h6E;
    push_read(7'h01, 8'h04);
    start(1'b1, 7'h01, 8'h04, 8'h00);
    wait_done("b2b_read", 2'b00, 1'b1, 8'h6E);
  endtask

  initial begin
    bus.req  = 1'b0;
    bus.rnw  = 1'b0;
    bus.dev  = 7'd0;
    bus.rga  = 8'h00;
    bus.wdat = 8'h00;
    test_reset();
    test_bsy_hold();
    test_write_delayed();
    test_read();
    test_nack();
    test_alo();
    test_bbl();
    test_reset_mid();
    test_fin_req_ignored();
    test_back_to_back();
    repeat (5) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
